// File: rtl/sb_pkg.sv
// Shared types and constants for the sideband TX path.
// Imported by the arbiter top and its round-robin picker.
package sb_pkg;

    localparam int SB_HDR_W      = 62;
    localparam int SB_DATA_W     = 64;
    localparam int SB_TX_TIMEOUT = 255;
    localparam int SB_TO_CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_HDR  = 3'd2,
        WAIT_DATA = 3'd3,
        DONE      = 3'd4
    } sb_tx_arb_state_e;

    function automatic int sb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping around, wins.
module sb_rr_arbiter
    import sb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = sb_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: picks one requester round-robin and walks the
// framer through header and optional data phases with a per-phase timeout.
module sb_tx_arbiter
    import sb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TIMEOUT_CYC = SB_TX_TIMEOUT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*SB_HDR_W-1:0]  i_req_header,
    input  logic [N_REQ*SB_DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]           o_req_ack,
    output logic [N_REQ-1:0]           o_req_done,
    output logic                       o_req_err,
    output logic [SB_HDR_W-1:0]        o_header,
    output logic [SB_DATA_W-1:0]       o_data,
    output logic                       o_header_valid,
    output logic                       o_d_valid,
    input  logic                       i_packet_valid,
    output logic                       o_busy
);

    localparam int IDX_W = sb_idx_w(N_REQ);
    localparam logic [SB_TO_CNT_W-1:0] TO_LIM = SB_TO_CNT_W'(TIMEOUT_CYC);

    sb_tx_arb_state_e       state_q, state_nx;
    logic [IDX_W-1:0]       rr_ptr_q, ptr_nxt;
    logic [SB_TO_CNT_W-1:0] to_cnt_q, to_nx, cnt_inc;
    logic                   err_q, err_nx;
    logic [SB_HDR_W-1:0]    hdr_q, arb_hdr;
    logic [SB_DATA_W-1:0]   data_q, arb_data;
    logic [IDX_W-1:0]       idx_q, arb_idx;
    logic [N_REQ-1:0]       arb_grant, idx_oh;
    logic                   arb_any;

    sb_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (i_req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign arb_hdr  = i_req_header[int'(arb_idx)*SB_HDR_W +: SB_HDR_W];
    assign arb_data = i_req_data[int'(arb_idx)*SB_DATA_W +: SB_DATA_W];
    assign cnt_inc  = to_cnt_q + SB_TO_CNT_W'(1);
    assign idx_oh   = N_REQ'(1) << idx_q;

    always_comb begin
        if (int'(idx_q) == N_REQ - 1)
            ptr_nxt = '0;
        else
            ptr_nxt = idx_q + IDX_W'(1);
    end

    // A phase pulse beats a simultaneous timeout.
    always_comb begin
        state_nx = state_q;
        to_nx    = to_cnt_q;
        err_nx   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any)
                    state_nx = ISSUE;
            end
            ISSUE: begin
                to_nx    = '0;
                state_nx = WAIT_HDR;
            end
            WAIT_HDR: begin
                if (i_packet_valid) begin
                    to_nx    = '0;
                    state_nx = (data_q != '0) ? WAIT_DATA : DONE;
                end else if (cnt_inc == TO_LIM) begin
                    to_nx    = '0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    to_nx = cnt_inc;
                end
            end
            WAIT_DATA: begin
                if (i_packet_valid) begin
                    to_nx    = '0;
                    state_nx = DONE;
                end else if (cnt_inc == TO_LIM) begin
                    to_nx    = '0;
                    err_nx   = 1'b1;
                    state_nx = DONE;
                end else begin
                    to_nx = cnt_inc;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            hdr_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_nx;
            to_cnt_q <= to_nx;
            err_q    <= err_nx;
            if (state_q == IDLE && arb_any) begin
                hdr_q  <= arb_hdr;
                data_q <= arb_data;
                idx_q  <= arb_idx;
            end
            if (state_q == DONE)
                rr_ptr_q <= ptr_nxt;
        end
    end

    assign o_busy         = (state_q != IDLE);
    assign o_header       = o_busy ? hdr_q : '0;
    assign o_data         = o_busy ? data_q : '0;
    assign o_header_valid = (state_q == ISSUE);
    assign o_d_valid      = (state_q == ISSUE);
    assign o_req_ack      = (state_q == ISSUE) ? idx_oh : '0;
    assign o_req_done     = (state_q == DONE) ? idx_oh : '0;
    assign o_req_err      = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: reset, header-only, data,
// round-robin, timeout, phase/timeout tie and mid-packet reset.
module tb_sb_tx_arbiter;

    localparam int N  = 3;
    localparam int HW = 62;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*HW-1:0] req_header;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_done;
    logic            req_err;
    logic [HW-1:0]   header;
    logic [DW-1:0]   data;
    logic            header_valid;
    logic            d_valid;
    logic            pv;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [HW-1:0] hdr [N];
    logic [DW-1:0] d2;

    always #5 clk = ~clk;

    sb_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(255)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_header   (req_header),
        .i_req_data     (req_data),
        .o_req_ack      (req_ack),
        .o_req_done     (req_done),
        .o_req_err      (req_err),
        .o_header       (header),
        .o_data         (data),
        .o_header_valid (header_valid),
        .o_d_valid      (d_valid),
        .i_packet_valid (pv),
        .o_busy         (busy)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %0h want 0", busy);
        end
        checks++;
        if (header !== '0 || data !== '0) begin
            errors++; $display("FAIL reset_hdr_data got %0h/%0h want 0", header, data);
        end
        checks++;
        if ({req_ack, req_done, req_err, header_valid, d_valid} !== '0) begin
            errors++;
            $display("FAIL reset_pulses got %0h/%0h/%0h/%0h/%0h want 0",
                     req_ack, req_done, req_err, header_valid, d_valid);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_header_only();
        logic early;
        early = 1'b0;
        req_header[0*HW +: HW] = hdr[0];
        req_data[0*DW +: DW]   = '0;
        req_valid = 3'b001;
        @(negedge clk);
        checks++;
        if (req_ack !== 3'b001 || header_valid !== 1'b1 || d_valid !== 1'b1) begin
            errors++;
            $display("FAIL ho_issue ack=%0b hv=%0b dv=%0b want 001/1/1", req_ack, header_valid, d_valid);
        end
        checks++;
        if (header !== hdr[0] || data !== '0) begin
            errors++; $display("FAIL ho_hdr got %0h/%0h want %0h/0", header, data, hdr[0]);
        end
        req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            if (req_done !== '0) early = 1'b1;
        end
        @(negedge clk);
        if (req_done !== '0) early = 1'b1;
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        checks++;
        if (early !== 1'b0) begin
            errors++; $display("FAIL ho_early_done got %0b want 0", early);
        end
        checks++;
        if (req_done !== 3'b001 || req_err !== 1'b0) begin
            errors++; $display("FAIL ho_done got %0b err=%0b want 001/0", req_done, req_err);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || header !== '0) begin
            errors++; $display("FAIL ho_idle busy=%0b hdr=%0h want 0/0", busy, header);
        end
    endtask

    task automatic test_data();
        req_header[1*HW +: HW] = hdr[1];
        req_data[1*DW +: DW]   = 64'hA5A5;
        req_valid = 3'b010;
        @(negedge clk);
        checks++;
        if (req_ack !== 3'b010 || d_valid !== 1'b1 || data !== 64'hA5A5) begin
            errors++; $display("FAIL dt_issue ack=%0b dv=%0b data=%0h want 010/1/a5a5", req_ack, d_valid, data);
        end
        req_valid = '0;
        @(negedge clk);
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        checks++;
        if (req_done !== '0 || busy !== 1'b1 || data !== 64'hA5A5) begin
            errors++;
            $display("FAIL dt_wait_data done=%0b busy=%0b data=%0h want 0/1/a5a5", req_done, busy, data);
        end
        @(negedge clk);
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        checks++;
        if (req_done !== 3'b010 || req_err !== 1'b0 || data !== 64'hA5A5) begin
            errors++;
            $display("FAIL dt_done done=%0b err=%0b data=%0h want 010/0/a5a5", req_done, req_err, data);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            req_header[k*HW +: HW] = hdr[k];
            req_data[k*DW +: DW]   = '0;
        end
        req_valid = 3'b111;
        for (int p = 0; p < 6; p++) begin
            exp = 3'b001 << (p % 3);
            n = 0;
            while (req_ack === '0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (req_ack !== exp || header !== hdr[p % 3]) begin
                errors++;
                $display("FAIL rr_grant%0d got %0b hdr=%0h want %0b hdr=%0h",
                         p, req_ack, header, exp, hdr[p % 3]);
            end
            @(negedge clk);
            pv = 1'b1;
            @(negedge clk);
            pv = 1'b0;
            checks++;
            if (req_done !== exp) begin
                errors++; $display("FAIL rr_done%0d got %0b want %0b", p, req_done, exp);
            end
        end
        req_valid = 3'b011;
    endtask

    task automatic test_timeout();
        int n;
        logic seen;
        n = 0;
        while (req_ack === '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ack !== 3'b001) begin
            errors++; $display("FAIL to_ack got %0b want 001", req_ack);
        end
        n = 0;
        while (req_done === '0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 256) begin
            errors++; $display("FAIL to_latency got %0d want 256", n);
        end
        checks++;
        if (req_done !== 3'b001 || req_err !== 1'b1) begin
            errors++; $display("FAIL to_done done=%0b err=%0b want 001/1", req_done, req_err);
        end
        @(negedge clk);
        checks++;
        if (req_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL to_after err=%0b busy=%0b want 0/0", req_err, busy);
        end
        n = 0;
        while (req_ack === '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ack !== 3'b010 || header !== hdr[1]) begin
            errors++; $display("FAIL to_next got %0b hdr=%0h want 010 hdr=%0h", req_ack, header, hdr[1]);
        end
        seen = 1'b0;
        repeat (255) begin
            @(negedge clk);
            if (req_done !== '0) seen = 1'b1;
        end
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL tie_early got %0b want 0", seen);
        end
        checks++;
        if (req_done !== 3'b010 || req_err !== 1'b0) begin
            errors++; $display("FAIL tie_done done=%0b err=%0b want 010/0", req_done, req_err);
        end
        req_valid = 3'b100;
    endtask

    task automatic test_reset_mid();
        int n;
        req_data[2*DW +: DW] = d2;
        n = 0;
        while (req_ack === '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ack !== 3'b100) begin
            errors++; $display("FAIL rm_ack got %0b want 100", req_ack);
        end
        @(negedge clk);
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        checks++;
        if (busy !== 1'b1 || req_done !== '0 || data !== d2) begin
            errors++; $display("FAIL rm_wait busy=%0b done=%0b data=%0h want 1/0/%0h", busy, req_done, data, d2);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, req_ack, req_done, req_err, header_valid, d_valid} !== '0 ||
            header !== '0 || data !== '0) begin
            errors++;
            $display("FAIL rm_cleared busy=%0b done=%0b hdr=%0h data=%0h want all 0",
                     busy, req_done, header, data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ack !== 3'b100 || header !== hdr[2]) begin
            errors++; $display("FAIL rm_reaccept got %0b hdr=%0h want 100 hdr=%0h", req_ack, header, hdr[2]);
        end
        req_valid = '0;
        @(negedge clk);
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        @(negedge clk);
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        checks++;
        if (req_done !== 3'b100 || req_err !== 1'b0) begin
            errors++; $display("FAIL rm_done done=%0b err=%0b want 100/0", req_done, req_err);
        end
        @(negedge clk);
    endtask

    initial begin
        hdr[0] = 62'h0AAA_0000_1111_2222;
        hdr[1] = 62'h1555_3333_4444_5555;
        hdr[2] = 62'h2BCD_6666_7777_8888;
        d2 = 64'hDEAD_BEEF_0000_0001;
        rst = 1'b1;
        req_valid = '0;
        req_header = '0;
        req_data = '0;
        pv = 1'b0;
        test_reset();
        test_header_only();
        test_data();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_tx_arbiter.md
SB_TX_ARBITER -- requirements
Module: sb_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, giving the number of sideband TX requesters (LTSM, RDI, completion).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum number of cycles to wait for each framer phase.
REQ-003 SHALL have port i_clk, input, 1 bit: the only clock.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_req_valid, input, N_REQ bits: level request per requester, held until acknowledged.
REQ-006 SHALL have port i_req_header, input, N_REQ*62 bits: packed headers, requester k at [k*62 +: 62].
REQ-007 SHALL have port i_req_data, input, N_REQ*64 bits: packed data, requester k at [k*64 +: 64]; all-zero means header-only.
REQ-008 SHALL have port o_req_ack, output, N_REQ bits: one-hot 1-cycle pulse when a request is accepted.
REQ-009 SHALL have port o_req_done, output, N_REQ bits: one-hot 1-cycle pulse when the packet completes or is aborted.
REQ-010 SHALL have port o_req_err, output, 1 bit: 1-cycle pulse coincident with o_req_done on timeout abort.
REQ-011 SHALL have port o_header, output, 62 bits: header presented to the framer.
REQ-012 SHALL have port o_data, output, 64 bits: data presented to the framer.
REQ-013 SHALL have port o_header_valid, output, 1 bit: header-valid pulse to the framer.
REQ-014 SHALL have port o_d_valid, output, 1 bit: data-valid pulse to the framer.
REQ-015 SHALL have port i_packet_valid, input, 1 bit: framer phase-emitted pulse.
REQ-016 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_HDR, WAIT_DATA, DONE.
REQ-018 IDLE: when any i_req_valid bit is set, SHALL select a requester by round-robin starting at rr_ptr, latch its header, data and index, and go to ISSUE at the next edge.
REQ-019 ISSUE (exactly 1 cycle): SHALL assert o_header_valid=1, o_d_valid=1 and o_req_ack[idx]=1, then go to WAIT_HDR.
REQ-020 o_d_valid SHALL always pulse, including for header-only packets, so the framer's data parity is ready.
REQ-021 o_header and o_data SHALL hold the latched values from ISSUE through DONE, and be zero in IDLE.
REQ-022 WAIT_HDR: on i_packet_valid, SHALL go to WAIT_DATA if the latched data is non-zero, otherwise to DONE.
REQ-023 WAIT_DATA: on i_packet_valid, SHALL go to DONE.
REQ-024 DONE (1 cycle): SHALL pulse o_req_done[idx], set rr_ptr to (idx+1) mod N_REQ, and go to IDLE.
REQ-025 Timeout counter: SHALL be 8 bits wide (wide enough for TIMEOUT_CYC), cleared in ISSUE and on every i_packet_valid, and increment in the WAIT states.
REQ-026 When the timeout counter reaches TIMEOUT_CYC in a WAIT state, SHALL go to DONE with o_req_err=1 and still advance rr_ptr.
REQ-027 i_packet_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-028 If i_packet_valid arrives on the same cycle as the timeout, the phase SHALL win (no error).
REQ-029 A requester dropping i_req_valid before ack is legal; arbitration SHALL use only the current-cycle request bits.
REQ-030 The minimum gap between back-to-back packets SHALL be IDLE→ISSUE (2 cycles after DONE), to let the framer clear its header-sent state.

Reset
REQ-031 On i_rst=1 at a clock edge, SHALL set state=IDLE, rr_ptr=0, timeout counter=0, and every output to 0, including o_header, o_data and o_busy.
REQ-032 Reset mid-packet SHALL abandon the packet without an o_req_done pulse.

Structure
REQ-033 Package sb_pkg SHALL hold the state enum sb_tx_arb_state_e, SB_HDR_W=62, SB_DATA_W=64 and the default SB_TX_TIMEOUT.
REQ-034 Sub-module sb_rr_arbiter SHALL implement the combinational round-robin pick (inputs: requests, pointer; outputs: one-hot grant, index, any).

Verification
REQ-035 Single header-only request: req0 with data=0, framer pulses i_packet_valid 3 cycles after ISSUE -> ack0 in ISSUE, one phase consumed, done0 in the next cycle plus 1, err=0.
REQ-036 Data request: req1 with data=64'hA5A5, two i_packet_valid pulses -> passes WAIT_DATA, done1 after the 2nd pulse, o_data stable throughout.
REQ-037 All three requesters continuously requesting -> grant order 0,1,2,0,1,2; no requester granted twice in a row.
REQ-038 No i_packet_valid after ISSUE -> done plus err exactly TIMEOUT_CYC cycles after entering WAIT_HDR, then the next requester is served.
REQ-039 i_rst asserted during WAIT_DATA -> the next cycle has all outputs 0, state IDLE, no done pulse; a held request is re-accepted afterwards.
